multicycle_ctrl: RTL

Multi-cycle control FSM for the lab CPU datapath. Sequences fetch, decode, execute and writeback for the supported R-type, I-type and LUI instruction classes. Consumes the instruction decoder's class flags (is_r/is_i/is_u) and 4-bit ALU op, and drives the IR/PC/register-file write enables and the ALU/writeback muxes. Also counts retired instructions and halts on illegal opcodes or fetch timeout.

---
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the lab CPU: fetch/decode/execute/writeback sequencing,
// retired-instruction counting, and halting on illegal decoder classes or fetch timeout.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ready,
    input  logic             is_r,
    input  logic             is_i,
    input  logic             is_u,
    input  logic [3:0]       alu_op_in,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             alu_b_sel,
    output logic             wb_sel,
    output logic [3:0]       alu_op,
    output logic [2:0]       state,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    // Counter value seen during the last permitted FETCH wait cycle.
    localparam logic [7:0] FETCH_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [1:0]       fault_q, fault_d;
    logic [3:0]       alu_op_q, alu_op_d;
    logic             b_sel_q, b_sel_d;
    logic             wb_sel_q, wb_sel_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            fault_q    <= FAULT_NONE;
            alu_op_q   <= '0;
            b_sel_q    <= 1'b0;
            wb_sel_q   <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            alu_op_q   <= alu_op_d;
            b_sel_q    <= b_sel_d;
            wb_sel_q   <= wb_sel_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        fault_d    = fault_q;
        alu_op_d   = alu_op_q;
        b_sel_d    = b_sel_q;
        wb_sel_d   = wb_sel_q;
        retired_d  = retired_q;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        rf_we      = 1'b0;
        alu_b_sel  = 1'b0;
        wb_sel     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_cnt_q == FETCH_LAST) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end

            S_DECODE: begin
                // The select registers double as the latched instruction class.
                case ({is_r, is_i, is_u})
                    3'b100: begin
                        alu_op_d = alu_op_in;
                        b_sel_d  = 1'b0;
                        wb_sel_d = 1'b0;
                        state_d  = S_EXEC;
                    end
                    3'b010: begin
                        alu_op_d = alu_op_in;
                        b_sel_d  = 1'b1;
                        wb_sel_d = 1'b0;
                        state_d  = S_EXEC;
                    end
                    3'b001: begin
                        alu_op_d = 4'b0000;
                        b_sel_d  = 1'b1;
                        wb_sel_d = 1'b1;
                        state_d  = S_EXEC;
                    end
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end

            S_EXEC: begin
                alu_b_sel = b_sel_q;
                wb_sel    = wb_sel_q;
                state_d   = S_WB;
            end

            S_WB: begin
                alu_b_sel = b_sel_q;
                wb_sel    = wb_sel_q;
                rf_we     = 1'b1;
                pc_we     = 1'b1;
                retired_d = retired_q + CNT_W'(1);
                state_d   = run ? S_FETCH : S_IDLE;
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_HALT;
                fault_d = FAULT_ILLEGAL;
            end
        endcase
    end

    assign alu_op  = alu_op_q;
    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule
